trip_sequencer: RTL and testbench

Trip controller for the taximeter. It tracks the trip phase (idle, running, parked, finished) from the driver keys and the park input. It turns raw wheel-sensor pulses into one-cycle distance-unit ticks, and parked time into wait-unit ticks. It also issues the clear pulse that resets the distance counter at the start of each trip; that counter and the fare logic consume its outputs.

---
 rtl/trip_sequencer.sv | 178 +++++++++++++++++
 tb/tb_trip_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/trip_sequencer.sv
// Taximeter trip controller: trip phase FSM, wheel-pulse to distance-unit ticks,
// parked time to wait-unit ticks. Optional auto-park on wheel stall: TRIP_AUTO_PARK_EN.
module trip_sequencer #(
  parameter int unsigned PULSES_PER_UNIT = 10,
  parameter int unsigned TICKS_PER_SEC   = 50_000_000,
  parameter int unsigned WAIT_SECONDS    = 60,
  parameter int unsigned STALL_CYCLES    = 150_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_trip,
  input  logic       end_trip,
  input  logic       park,
  input  logic       wheel_pulse,
  output logic       dist_restart,
  output logic       dist_tick,
  output logic       wait_tick,
  output logic [1:0] state,
  output logic       trip_done
);

  localparam int unsigned PW  = $clog2(PULSES_PER_UNIT);
  localparam int unsigned TW  = $clog2(TICKS_PER_SEC);
  localparam int unsigned SW  = (WAIT_SECONDS > 1) ? $clog2(WAIT_SECONDS) : 1;
  localparam int unsigned STW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  // Elaboration-time parameter range checks
  if (PULSES_PER_UNIT < 2) begin : g_chk_ppu
    $error("PULSES_PER_UNIT must be >= 2");
  end
  if (TICKS_PER_SEC < 2) begin : g_chk_tps
    $error("TICKS_PER_SEC must be >= 2");
  end
  if (WAIT_SECONDS < 1) begin : g_chk_ws
    $error("WAIT_SECONDS must be >= 1");
  end
  if (STALL_CYCLES < 2) begin : g_chk_stall
    $error("STALL_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_PARK = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t          st;
  logic            sync1, sync2, sync3, edge_q;
  logic [PW-1:0]   pcnt;
  logic [TW-1:0]   presc;
  logic [SW-1:0]   secs;
`ifdef TRIP_AUTO_PARK_EN
  logic [STW-1:0]  stall;
  logic            auto_park;
`endif

  assign state = st;

  // Wheel sensor synchronizer with registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= wheel_pulse;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 & ~sync3;
    end
  end

  // Trip FSM with distance/wait counters; trip start overrides counter updates
  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= S_IDLE;
      dist_restart <= 1'b0;
      dist_tick    <= 1'b0;
      wait_tick    <= 1'b0;
      trip_done    <= 1'b0;
      pcnt         <= '0;
      presc        <= '0;
      secs         <= '0;
`ifdef TRIP_AUTO_PARK_EN
      stall        <= '0;
      auto_park    <= 1'b0;
`endif
    end else begin
      dist_restart <= 1'b0;
      dist_tick    <= 1'b0;
      wait_tick    <= 1'b0;
      trip_done    <= 1'b0;

      if (edge_q && (st == S_RUN)) begin
        if (pcnt == PW'(PULSES_PER_UNIT - 1)) begin
          pcnt      <= '0;
          dist_tick <= 1'b1;
        end else begin
          pcnt <= pcnt + PW'(1);
        end
      end

      // Wait time accumulates only while parked and holds otherwise
      if (st == S_PARK) begin
        if (presc == TW'(TICKS_PER_SEC - 1)) begin
          presc <= '0;
          if (secs == SW'(WAIT_SECONDS - 1)) begin
            secs      <= '0;
            wait_tick <= 1'b1;
          end else begin
            secs <= secs + SW'(1);
          end
        end else begin
          presc <= presc + TW'(1);
        end
      end

`ifdef TRIP_AUTO_PARK_EN
      if (st == S_RUN) begin
        stall <= edge_q ? '0 : stall + STW'(1);
      end
`endif

      case (st)
        S_IDLE, S_DONE: begin
          if (start_trip) begin
            st           <= S_RUN;
            dist_restart <= 1'b1;
            pcnt         <= '0;
            presc        <= '0;
            secs         <= '0;
`ifdef TRIP_AUTO_PARK_EN
            stall        <= '0;
`endif
          end
        end
        S_RUN: begin
          if (end_trip) begin
            st        <= S_DONE;
            trip_done <= 1'b1;
          end else if (park) begin
            st <= S_PARK;
`ifdef TRIP_AUTO_PARK_EN
          end else if (!edge_q && (stall == STW'(STALL_CYCLES - 1))) begin
            st        <= S_PARK;
            auto_park <= 1'b1;
`endif
          end
        end
        S_PARK: begin
`ifdef TRIP_AUTO_PARK_EN
          // An auto-parked vehicle resumes only on wheel movement
          if (end_trip) begin
            st        <= S_DONE;
            trip_done <= 1'b1;
            auto_park <= 1'b0;
          end else if (!park && (!auto_park || edge_q)) begin
            st        <= S_RUN;
            stall     <= '0;
            auto_park <= 1'b0;
          end
`else
          if (end_trip) begin
            st        <= S_DONE;
            trip_done <= 1'b1;
          end else if (!park) begin
            st <= S_RUN;
          end
`endif
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trip_sequencer.sv
// Directed self-checking bench for trip_sequencer with small parameters
// (PULSES_PER_UNIT=4, TICKS_PER_SEC=5, WAIT_SECONDS=2, STALL_CYCLES=20).
module tb_trip_sequencer;

  logic       clk;
  logic       reset;
  logic       start_trip;
  logic       end_trip;
  logic       park;
  logic       wheel_pulse;
  logic       dist_restart;
  logic       dist_tick;
  logic       wait_tick;
  logic [1:0] state;
  logic       trip_done;

  int checks;
  int errors;
  int dticks;
  int wticks;
  int d0;

  trip_sequencer #(
    .PULSES_PER_UNIT(4),
    .TICKS_PER_SEC  (5),
    .WAIT_SECONDS   (2),
    .STALL_CYCLES   (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_trip  (start_trip),
    .end_trip    (end_trip),
    .park        (park),
    .wheel_pulse (wheel_pulse),
    .dist_restart(dist_restart),
    .dist_tick   (dist_tick),
    .wait_tick   (wait_tick),
    .state       (state),
    .trip_done   (trip_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    if (dist_tick) dticks++;
    if (wait_tick) wticks++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two cycles high, two low; dist_tick for this pulse is visible at the end
  task automatic wheel();
    wheel_pulse = 1'b1;
    steps(2);
    wheel_pulse = 1'b0;
    steps(2);
  endtask

  task automatic do_start();
    start_trip = 1'b1;
    step();
    start_trip = 1'b0;
  endtask

  task automatic do_end();
    end_trip = 1'b1;
    step();
    end_trip = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; dticks = 0; wticks = 0; d0 = 0;
    reset = 1'b1; start_trip = 1'b0; end_trip = 1'b0; park = 1'b0; wheel_pulse = 1'b0;
    steps(2);

    // Reset state
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", {27'd0, dist_restart, dist_tick, wait_tick, trip_done, 1'b0}, 32'd0);
    reset = 1'b0;
    step();

    // Trip start from IDLE
    do_start();
    chk("start_state", 32'(state), 32'd1);
    chk("start_restart", 32'(dist_restart), 32'd1);
    chk("start_dtick", 32'(dist_tick), 32'd0);
    step();
    chk("restart_once", 32'(dist_restart), 32'd0);

    // Nine pulses: ticks on the 4th and 8th only
    dticks = 0;
    for (int i = 1; i <= 9; i++) begin
      wheel();
      chk($sformatf("dtick_p%0d", i), 32'(dist_tick), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    steps(3);
    chk("dtick_total", 32'(dticks), 32'd2);

    // End of trip
    do_end();
    chk("end_state", 32'(state), 32'd3);
    chk("trip_done", 32'(trip_done), 32'd1);
    step();
    chk("trip_done_once", 32'(trip_done), 32'd0);

    // Restart from DONE, then 12 park cycles give exactly one wait_tick
    do_start();
    chk("restart_done_state", 32'(state), 32'd1);
    chk("restart_done_pulse", 32'(dist_restart), 32'd1);
    wticks = 0;
    park = 1'b1;
    step();
    chk("park_state", 32'(state), 32'd2);
    for (int i = 1; i <= 11; i++) begin
      step();
      chk($sformatf("wtick_c%0d", i), 32'(wait_tick), (i == 10) ? 32'd1 : 32'd0);
    end
    park = 1'b0;
    step();
    chk("unpark_state", 32'(state), 32'd1);
    chk("wtick_total", 32'(wticks), 32'd1);

    // Wheel pulses while parked do not count
    park = 1'b1;
    step();
    d0 = dticks;
    for (int i = 0; i < 4; i++) wheel();
    chk("park_no_dtick", 32'(dticks - d0), 32'd0);
    chk("park_hold", 32'(state), 32'd2);
    park = 1'b0;
    step();
    chk("park_release", 32'(state), 32'd1);

    // end_trip has priority over park
    end_trip = 1'b1; park = 1'b1;
    step();
    end_trip = 1'b0; park = 1'b0;
    chk("prio_state", 32'(state), 32'd3);
    chk("prio_done", 32'(trip_done), 32'd1);

    // Partial count survives park/unpark
    do_start();
    d0 = dticks;
    for (int i = 0; i < 3; i++) wheel();
    chk("partial3", 32'(dticks - d0), 32'd0);
    park = 1'b1;
    steps(2);
    park = 1'b0;
    step();
    chk("partial_run", 32'(state), 32'd1);
    wheel();
    chk("partial_tick", 32'(dist_tick), 32'd1);
    start_trip = 1'b1;
    step();
    start_trip = 1'b0;
    chk("start_in_run_ign", 32'(dist_restart), 32'd0);
    wheel();
    wheel();
    // Trip restart clears the two leftover counts
    do_end();
    do_start();
    d0 = dticks;
    for (int i = 0; i < 3; i++) wheel();
    chk("cleared3", 32'(dticks - d0), 32'd0);
    wheel();
    chk("cleared4_tick", 32'(dist_tick), 32'd1);
    steps(2);

    // Stall behaviour
    do_end();
    do_start();
`ifdef TRIP_AUTO_PARK_EN
    steps(19);
    chk("stall_run", 32'(state), 32'd1);
    step();
    chk("stall_park", 32'(state), 32'd2);
    steps(3);
    chk("autopark_hold", 32'(state), 32'd2);
    d0 = dticks;
    wheel();
    chk("autopark_resume", 32'(state), 32'd1);
    chk("autopark_no_dtick", 32'(dticks - d0), 32'd0);
`else
    steps(30);
    chk("no_autopark", 32'(state), 32'd1);
`endif

    // Reset mid-trip returns to IDLE without a restart pulse
    reset = 1'b1;
    step();
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_restart", 32'(dist_restart), 32'd0);
    reset = 1'b0;
    step();
    chk("midrst_idle", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
